uart_tx_slave: RTL
==================

Name: uart_tx_slave

Overview:
- Memory-mapped UART transmitter that acts as a responder on the D-bus, alongside the memory and GPIO slaves. The D-bus interconnect decodes its window and drives ss.
- The core writes bytes into a TX FIFO. A serializer drains the FIFO onto a single 8N1 line at a programmable bit period.
- Ports are flat; a thin wrapper maps them onto slave_bus_if.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, at least 2.
- DEFAULT_DIV, 16'd16, reset value of BAUDDIV, in clocks per bit.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ss  input  1  slave select from the D-bus interconnect.
- bstart  input  1  transaction start strobe.
- addr  input  4  byte offset within the window; addr[1:0] ignored.
- ttype  input  1  0=READ, 1=WRITE.
- tsize  input  2  BYTE/HALFWORD/WORD; the low bits of wdata are used for every size.
- wdata  input  32  write data.
- rdata  output  32  read data, valid while bdone=1.
- bdone  output  1  one-cycle transaction completion.
- tx  output  1  serial line, idle high.
- irq  output  1  high while the FIFO is empty and the serializer is idle.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - tx=1, bdone=0, rdata=0, irq=1.
  - FIFO empty, overflow=0, BAUDDIV=DEFAULT_DIV, FSM in IDLE.
  - Reset mid-frame aborts the frame immediately; tx returns to 1.
- Bus handshake:
  - A transaction is sampled on the rising edge where ss&&bstart=1.
  - bdone=1 for exactly one cycle on the next cycle. There are no wait states.
  - Transactions on back-to-back cycles each get their own bdone.
  - ss=0 or bstart=0: no side effect, bdone=0.
- Register map (offset):
  - 0x0 TXDATA (WO): a write pushes wdata[7:0]. If the FIFO is full at the sampling edge, the byte is dropped and overflow is set. This holds even if a pop occurs on the same edge. Reads return 0.
  - 0x4 STATUS: read returns {28'b0, overflow, busy, empty, full}. Writing 1 to bit3 clears overflow; set takes priority over clear on the same edge.
  - 0x8 BAUDDIV (RW): write loads wdata[15:0]; a written 0 is stored as 1. Read returns {16'b0, div}. A new value takes effect at the next bit boundary.
  - 0xC and any undecoded offset: read 0, write ignored, bdone still pulses.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH)+1 bits.
  - full when the pointers differ only in the MSB; empty when they are equal.
  - Simultaneous push and pop with the FIFO not full: both occur and the count is unchanged.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - A bit counter counts div clocks per bit; a 3-bit index tracks the data bit.
  - IDLE: tx=1. If the FIFO is not empty, pop into the shift register; the next cycle enters START.
  - START: tx=0 for div cycles, then DATA with index 0.
  - DATA: tx=shift[0] (LSB first) for div cycles, then shift right. After index 7, go to STOP.
  - STOP: tx=1 for div cycles. Then, if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - busy=1 in every state except IDLE.
  - One frame lasts 10*div cycles.
- Latency: a TXDATA write sampled at edge N into an empty FIFO with the FSM idle gives tx=0 from cycle N+2.

Test Plan:
- Reset values: assert rst_n=0 mid-frame → tx=1 immediately. After release, STATUS reads 0x2 and BAUDDIV reads 0x0010.
- Single byte: write BAUDDIV=4, write TXDATA=0x55 → tx=0 for 4 clks, then bits 1,0,1,0,1,0,1,0 for 4 clks each, then stop 1 for 4 clks. busy is high for 40 clks, then irq=1.
- Back-to-back frames: div=2, write 0xA5 then 0x3C → the two 20-cycle frames are contiguous and the start bit of 0x3C immediately follows the stop bit of 0xA5.
- Overflow: div=100, write 10 bytes rapidly with FIFO_DEPTH=8 → the first byte is popped into the shifter, the next 8 fill the FIFO, and the 10th is dropped. STATUS=0xD (overflow, busy, full). Writing 0x8 to STATUS clears overflow, leaving 0x5.
- Divider edge: write BAUDDIV=0 → reads back 0x0001, and the frame for 0xFF lasts 10 clocks.
- Bus protocol: a read of 0xC returns 0 with bdone. bstart with ss=0 → no bdone. Three consecutive STATUS reads → three single-cycle bdone pulses.

Source files
------------

// File: rtl/uart_tx_slave.sv
// Memory-mapped 8N1 UART transmitter on the D-bus: TX FIFO, baud divider,
// status/overflow register and a serializer that drains the FIFO LSB first.
module uart_tx_slave #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ss,
  input  logic        bstart,
  input  logic [3:0]  addr,
  input  logic        ttype,
  input  logic [1:0]  tsize,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        bdone,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] R_TXDATA  = 2'd0;
  localparam logic [1:0] R_STATUS  = 2'd1;
  localparam logic [1:0] R_BAUDDIV = 2'd2;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          full, empty, push, pop;
  logic          ovf;
  logic [15:0]   div;
  logic [15:0]   bdiv, bdiv_d;
  logic [15:0]   cnt, cnt_d;
  logic [1:0]    state, state_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic          busy, bit_end;
  logic          req, wr;
  logic [31:0]   rd_val;
  logic          unused_bits;

  assign unused_bits = ^{addr[1:0], tsize, wdata[31:16]};

  assign req   = ss & bstart;
  assign wr    = req & ttype;
  assign empty = (wptr == rptr);
  assign full  = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
  assign push  = wr && (addr[3:2] == R_TXDATA) && !full;
  assign busy  = (state != S_IDLE);

  // Read mux, sampled on the request edge
  always_comb begin
    rd_val = 32'd0;
    case (addr[3:2])
      R_STATUS:  rd_val = {28'd0, ovf, busy, empty, full};
      R_BAUDDIV: rd_val = {16'd0, div};
      default:   rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bdone <= 1'b0;
      rdata <= 32'd0;
    end else begin
      bdone <= req;
      rdata <= (req && !ttype) ? rd_val : 32'd0;
    end
  end

  // Control registers; a set of overflow wins over a clear on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= DEFAULT_DIV;
      ovf <= 1'b0;
    end else begin
      if (wr && (addr[3:2] == R_BAUDDIV))
        div <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
      if (wr && (addr[3:2] == R_TXDATA) && full)
        ovf <= 1'b1;
      else if (wr && (addr[3:2] == R_STATUS) && wdata[3])
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[AW-1:0]] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 16'd0;
      bdiv  <= 16'd1;
      idx   <= 3'd0;
      shift <= 8'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      bdiv  <= bdiv_d;
      idx   <= idx_d;
      shift <= shift_d;
    end
  end

  // Serializer next state; the divider is latched at every bit boundary
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bdiv_d  = bdiv;
    idx_d   = idx;
    shift_d = shift;
    pop     = 1'b0;
    bit_end = (cnt == 16'(bdiv - 16'd1));
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rptr[AW-1:0]];
          state_d = S_START;
          cnt_d   = 16'd0;
          bdiv_d  = div;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          cnt_d   = 16'd0;
          bdiv_d  = div;
        end else begin
          cnt_d = 16'(cnt + 16'd1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift[7:1]};
          cnt_d   = 16'd0;
          bdiv_d  = div;
          if (idx == 3'd7) state_d = S_STOP;
          else             idx_d   = 3'(idx + 3'd1);
        end else begin
          cnt_d = 16'(cnt + 16'd1);
        end
      end
      default: begin
        if (bit_end) begin
          cnt_d  = 16'd0;
          bdiv_d = div;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rptr[AW-1:0]];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = 16'(cnt + 16'd1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx  <= 1'b1;
      irq <= 1'b1;
    end else begin
      case (state)
        S_START: tx <= 1'b0;
        S_DATA:  tx <= shift[0];
        default: tx <= 1'b1;
      endcase
      irq <= empty && (state == S_IDLE);
    end
  end

endmodule
